// File: rtl/alu_issue.sv
// ---------------------------------------------------------------------------
// alu_issue
//
// Single-entry issue wrapper around a combinational ALU. One operation is in
// flight at a time. The operation is latched from the requester, presented to
// the ALU for one cycle, and the ALU result and flags are captured and held
// until the consumer takes them.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   req_valid/req_ready request handshake
//   req_op/req_a/req_b  operation code and operands from the requester
//   aluop/alu_a/alu_b   operation and operands driven to the ALU
//   alu_out, alu_*      ALU result and flags (negative, overflow, zero)
//   resp_valid/ready    response handshake
//   resp_out, resp_*    captured result and flags
//   perf_cnt            completed responses, saturating at all-ones
//   ovf_trap, trap_clr  sticky overflow trap and its clear (only when
//                       ALU_OVF_TRAP_EN is defined)
//
// Optional feature macro: ALU_OVF_TRAP_EN
//
// Opcode values follow the cpu_types_pkg aluop_t encoding; only ADD and SUB
// are needed here, for the trap.
// ---------------------------------------------------------------------------
module alu_issue #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  output logic [3:0]       aluop,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  logic [31:0]      alu_out,
  input  logic             alu_negative,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_out,
  output logic             resp_negative,
  output logic             resp_overflow,
  output logic             resp_zero,
  output logic [CNT_W-1:0] perf_cnt
`ifdef ALU_OVF_TRAP_EN
  ,
  output logic             ovf_trap,
  input  logic             trap_clr
`endif
);

  // state | meaning
  // ------+--------------------------------------------------------------
  // IDLE  | ready for a request; ALU still sees the last operation
  // EXEC  | operand registers drive the ALU; result captured at cycle end
  // RESP  | response held valid until resp_ready

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

`ifdef ALU_OVF_TRAP_EN
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;
`endif

  state_t state_q, state_d;

  logic [3:0]       op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      res_q, res_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic [CNT_W-1:0] perf_q, perf_d;
`ifdef ALU_OVF_TRAP_EN
  logic             trap_q, trap_d;
`endif

  // Control strobes from the output process.
  logic accept;
  logic capture;
  logic complete;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM outputs
  // -------------------------------------------------------------------------
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    complete   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        accept    = req_valid;
      end
      ST_EXEC: begin
        capture = 1'b1;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        complete   = resp_ready;
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath next values
  // -------------------------------------------------------------------------
  always_comb begin
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    res_d  = res_q;
    neg_d  = neg_q;
    ovf_d  = ovf_q;
    zero_d = zero_q;
    perf_d = perf_q;

    if (accept) begin
      op_d = req_op;
      a_d  = req_a;
      b_d  = req_b;
    end

    // Flags are taken from the ALU as-is, never recomputed here.
    if (capture) begin
      res_d  = alu_out;
      neg_d  = alu_negative;
      ovf_d  = alu_overflow;
      zero_d = alu_zero;
    end

    // Saturate instead of wrapping so a long run never reads as a short one.
    if (complete && (perf_q != {CNT_W{1'b1}})) begin
      perf_d = perf_q + CNT_W'(1);
    end
  end

`ifdef ALU_OVF_TRAP_EN
  // Set has priority over clear so an overflow in the clearing cycle is kept.
  always_comb begin
    trap_d = trap_q;
    if (trap_clr) begin
      trap_d = 1'b0;
    end
    if (capture && alu_overflow && ((op_q == ALU_ADD) || (op_q == ALU_SUB))) begin
      trap_d = 1'b1;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q   <= 4'd0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      res_q  <= 32'd0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      perf_q <= '0;
    end else begin
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      res_q  <= res_d;
      neg_q  <= neg_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      perf_q <= perf_d;
    end
  end

`ifdef ALU_OVF_TRAP_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= trap_d;
    end
  end

  assign ovf_trap = trap_q;
`endif

  // The ALU only ever sees the operand registers, so it holds the last
  // operation while idle and never glitches with req_* activity.
  assign aluop         = op_q;
  assign alu_a         = a_q;
  assign alu_b         = b_q;
  assign resp_out      = res_q;
  assign resp_negative = neg_q;
  assign resp_overflow = ovf_q;
  assign resp_zero     = zero_q;
  assign perf_cnt      = perf_q;

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

  localparam logic [3:0] OP_SLL  = 4'h0;
  localparam logic [3:0] OP_SRL  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOR  = 4'h7;
  localparam logic [3:0] OP_SLT  = 4'hA;
  localparam logic [3:0] OP_SLTU = 4'hB;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = 3;

  logic             CLK;
  logic             RST;
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [3:0]       aluop;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [31:0]      alu_out;
  logic             alu_negative;
  logic             alu_overflow;
  logic             alu_zero;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_out;
  logic             resp_negative;
  logic             resp_overflow;
  logic             resp_zero;
  logic [CNT_W-1:0] perf_cnt;
`ifdef ALU_OVF_TRAP_EN
  logic             ovf_trap;
  logic             trap_clr;
`endif

  int          n_chk = 0;
  int          n_pass = 0;
  logic [34:0] exp_q[$];       // {negative, overflow, zero, result}
  int          exp_cnt = 0;
  logic [3:0]  last_op = 4'd0;
  logic [31:0] last_a = 32'd0;
  logic [31:0] last_b = 32'd0;

  logic [3:0] ops [12] = '{OP_SLL, OP_SRL, OP_ADD, OP_SUB, OP_AND, OP_OR,
                           OP_XOR, OP_NOR, OP_SLT, OP_SLTU, 4'h8, 4'hF};

  alu_issue #(.CNT_W(CNT_W)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_a         (req_a),
    .req_b         (req_b),
    .aluop         (aluop),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_out       (alu_out),
    .alu_negative  (alu_negative),
    .alu_overflow  (alu_overflow),
    .alu_zero      (alu_zero),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_out      (resp_out),
    .resp_negative (resp_negative),
    .resp_overflow (resp_overflow),
    .resp_zero     (resp_zero),
    .perf_cnt      (perf_cnt)
`ifdef ALU_OVF_TRAP_EN
    ,
    .ovf_trap      (ovf_trap),
    .trap_clr      (trap_clr)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural ALU: signed overflow taken from exact 64-bit arithmetic.
  function automatic logic [34:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      wide;
    logic [31:0] r;
    logic        v;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    wide = 0;
    r    = 32'd0;
    v    = 1'b0;
    case (op)
      OP_SLL:  r = a << b[4:0];
      OP_SRL:  r = a >> b[4:0];
      OP_ADD:  begin wide = sa + sb; r = 32'(wide);
                 v = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
      OP_SUB:  begin wide = sa - sb; r = 32'(wide);
                 v = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return {r[31], v, (r == 32'd0), r};
  endfunction

  assign {alu_negative, alu_overflow, alu_zero, alu_out} = ref_alu(aluop, alu_a, alu_b);

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", nm, act, exp);
  endtask

  task automatic push_exp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_q.push_back(ref_alu(op, a, b));
    last_op = op;
    last_a  = a;
    last_b  = b;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    n = 0;
    @(negedge CLK);
    while (!req_ready && n < 20) begin
      n++;
      @(negedge CLK);
    end
    chk1("issue_accept", req_ready, 1'b1);
    if (req_ready && !RST) push_exp(op, a, b);
    @(posedge CLK); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    RST       = 1'b1;
    req_valid = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST     = 1'b0;
    last_op = 4'd0;
    last_a  = 32'd0;
    last_b  = 32'd0;
  endtask

  // Monitor: RST and resp_ready seen here are what the next rising edge samples.
  always @(negedge CLK) begin
    chk32("perf_cnt", 32'(perf_cnt), 32'(exp_cnt));
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        chk1("resp_unexpected", resp_valid, 1'b0);
      end else begin
        chk32("resp_out", resp_out, exp_q[0][31:0]);
        chk1("resp_zero", resp_zero, exp_q[0][32]);
        chk1("resp_overflow", resp_overflow, exp_q[0][33]);
        chk1("resp_negative", resp_negative, exp_q[0][34]);
        if (resp_ready && !RST) begin
          void'(exp_q.pop_front());
          if (exp_cnt < CNT_MAX) exp_cnt++;
        end
      end
    end
    if (RST) begin
      exp_q.delete();
      exp_cnt = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks so far %0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    RST        = 1'b1;
    req_valid  = 1'b0;
    req_op     = 4'd0;
    req_a      = 32'd0;
    req_b      = 32'd0;
    resp_ready = 1'b0;
`ifdef ALU_OVF_TRAP_EN
    trap_clr   = 1'b0;
`endif

    // Reset state
    @(posedge CLK); #1;
    @(negedge CLK);
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_resp_valid", resp_valid, 1'b0);
    chk32("rst_aluop", 32'(aluop), 32'd0);
    chk32("rst_alu_a", alu_a, 32'd0);
    chk32("rst_alu_b", alu_b, 32'd0);
    chk32("rst_resp_out", resp_out, 32'd0);
    chk1("rst_resp_neg", resp_negative, 1'b0);
    chk1("rst_resp_ovf", resp_overflow, 1'b0);
    chk1("rst_resp_zero", resp_zero, 1'b0);
`ifdef ALU_OVF_TRAP_EN
    chk1("rst_ovf_trap", ovf_trap, 1'b0);
`endif
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk1("ready_after_release", req_ready, 1'b1);

    // ADD overflow with latency
    resp_ready = 1'b1;
    @(posedge CLK); #1;
    issue(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    @(negedge CLK);
    chk1("lat_exec_valid", resp_valid, 1'b0);
    chk1("lat_exec_ready", req_ready, 1'b0);
    @(negedge CLK);
    chk1("lat_resp_valid", resp_valid, 1'b1);
    chk32("add_out", resp_out, 32'h8000_0000);
    chk1("add_neg", resp_negative, 1'b1);
    chk1("add_ovf", resp_overflow, 1'b1);
    chk1("add_zero", resp_zero, 1'b0);
    @(negedge CLK);
    chk32("add_perf", 32'(perf_cnt), 32'd1);
    chk1("add_ready_back", req_ready, 1'b1);

    // SUB to zero; ready low for exactly two cycles
    @(posedge CLK); #1;
    issue(OP_SUB, 32'd5, 32'd5);
    @(negedge CLK);
    chk1("sub_ready_low1", req_ready, 1'b0);
    @(negedge CLK);
    chk1("sub_ready_low2", req_ready, 1'b0);
    chk32("sub_out", resp_out, 32'd0);
    chk1("sub_zero", resp_zero, 1'b1);
    chk1("sub_neg", resp_negative, 1'b0);
    @(negedge CLK);
    chk1("sub_ready_back", req_ready, 1'b1);

    // SLT with 4-cycle stall and ignored request pulses
    resp_ready = 1'b0;
    @(posedge CLK); #1;
    issue(OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001);
    @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      req_valid = (i % 2 == 0);
      req_op    = OP_ADD;
      req_a     = $urandom;
      req_b     = $urandom;
      @(negedge CLK);
      chk1("stall_req_ready", req_ready, 1'b0);
      chk1("stall_resp_valid", resp_valid, 1'b1);
      chk32("stall_resp_out", resp_out, 32'd1);
    end
    @(posedge CLK); #1;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk1("slt_ready_back", req_ready, 1'b1);
    chk32("slt_alu_a_held", alu_a, 32'hFFFF_FFFF);

    // Reset during EXEC
    @(posedge CLK); #1;
    issue(OP_AND, $urandom, $urandom);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk1("rst_exec_resp_valid", resp_valid, 1'b0);
    chk1("rst_exec_req_ready", req_ready, 1'b1);
    chk32("rst_exec_perf", 32'(perf_cnt), 32'd0);
    chk32("rst_exec_aluop", 32'(aluop), 32'd0);
    repeat (3) @(negedge CLK);

    // Saturating counter: five ORs
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      issue(OP_OR, $urandom, $urandom);
      @(negedge CLK);
      @(negedge CLK);
      @(negedge CLK);
      chk32("perf_seq", 32'(perf_cnt), (i + 1 > CNT_MAX) ? 32'(CNT_MAX) : 32'(i + 1));
    end

    // Unrecognised opcode
    @(posedge CLK); #1;
    issue(4'hF, $urandom, $urandom);
    @(negedge CLK);
    @(negedge CLK);
    chk32("unk_out", resp_out, 32'd0);
    chk1("unk_zero", resp_zero, 1'b1);

    // Random traffic with random back-pressure
    do_reset();
    for (int c = 0; c < 800; c++) begin
      resp_ready = ($urandom_range(0, 3) != 0);
      req_valid  = ($urandom_range(0, 1) == 1);
      req_op     = ops[$urandom_range(0, 11)];
      req_a      = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
      req_b      = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      @(negedge CLK);
      chk32("alu_a_hold", alu_a, last_a);
      chk32("alu_b_hold", alu_b, last_b);
      chk32("aluop_hold", 32'(aluop), 32'(last_op));
      if (req_valid && req_ready) push_exp(req_op, req_a, req_b);
      @(posedge CLK); #1;
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    repeat (4) @(negedge CLK);
    chk32("drain_empty", 32'(exp_q.size()), 32'd0);

`ifdef ALU_OVF_TRAP_EN
    do_reset();
    @(negedge CLK);
    chk1("trap_after_reset", ovf_trap, 1'b0);
    @(posedge CLK); #1;
    issue(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    @(negedge CLK);
    chk1("trap_during_exec", ovf_trap, 1'b0);
    @(negedge CLK);
    chk1("trap_set", ovf_trap, 1'b1);
    @(negedge CLK);
    @(posedge CLK); #1;
    issue(OP_SUB, 32'h8000_0000, 32'h0000_0001);
    trap_clr = 1'b1;
    @(posedge CLK); #1;
    trap_clr = 1'b0;
    @(negedge CLK);
    chk1("trap_set_wins", ovf_trap, 1'b1);
    @(negedge CLK);
    @(posedge CLK); #1;
    trap_clr = 1'b1;
    @(posedge CLK); #1;
    trap_clr = 1'b0;
    @(negedge CLK);
    chk1("trap_cleared", ovf_trap, 1'b0);
`endif

    repeat (2) @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter CNT_W, default 16, width of completed-operation counter perf_cnt.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  requester presents an operation.
REQ-005 req_ready  output  1  block can accept an operation.
REQ-006 req_op  input  4  aluop_t operation code (cpu_types_pkg encoding).
REQ-007 req_a / req_b  input  32 each  operands, ALU port a and port b semantics.
REQ-008 aluop  output  4  operation driven to ALU.
REQ-009 alu_a / alu_b  output  32 each  operands driven to ALU.
REQ-010 alu_out  input  32  ALU result.
REQ-011 alu_negative / alu_overflow / alu_zero  input  1 each  ALU flags.
REQ-012 resp_valid  output  1  result and flags available.
REQ-013 resp_ready  input  1  consumer accepts the response.
REQ-014 resp_out  output  32  captured result.
REQ-015 resp_negative / resp_overflow / resp_zero  output  1 each  captured flags.
REQ-016 perf_cnt  output  CNT_W  completed responses, saturating.
REQ-017 ovf_trap  output  1  sticky overflow trap (present only with ALU_OVF_TRAP_EN).
REQ-018 trap_clr  input  1  clears ovf_trap (present only with ALU_OVF_TRAP_EN).

Function
REQ-019 FSM states IDLE, EXEC, RESP; exactly one active.
REQ-020 IDLE: req_ready=1, resp_valid=0; req_valid=1 latches req_op/req_a/req_b into operand registers, next state EXEC.
REQ-021 EXEC: req_ready=0; aluop/alu_a/alu_b driven from operand registers; alu_out and all three flags captured into response registers at end of cycle; next state RESP unconditionally.
REQ-022 RESP: resp_valid=1, req_ready=0; resp_ready=1 completes transfer, next state IDLE; else remain in RESP.
REQ-023 ALU outputs driven from operand registers in every state (never directly from req_*), holding last operation when idle.
REQ-024 Latency: request accepted at edge N gives resp_valid=1 in cycle N+2; maximum throughput one operation per 3 cycles.
REQ-025 While resp_valid=1 and resp_ready=0, resp_out and resp flags held stable, unchanged cycle to cycle.
REQ-026 req_valid ignored outside IDLE; no request is queued or lost-accepted (req_ready=0).
REQ-027 Unrecognised opcodes passed to ALU unchanged; response carries whatever ALU returns (zero result, zero=1).
REQ-028 perf_cnt increments by 1 on each RESP handshake (resp_valid & resp_ready); saturates at 2^CNT_W-1, never wraps.
REQ-029 Flags are captured, not recomputed; resp_overflow meaningful only for ALU_ADD/ALU_SUB.

Reset
REQ-030 RST=1 at a rising edge forces state IDLE, regardless of current state, including mid-EXEC or mid-RESP.
REQ-031 Reset values: operand registers 0, aluop 0, response registers 0, all resp flags 0, resp_valid 0, perf_cnt 0, ovf_trap 0.
REQ-032 req_ready=1 in the first cycle after reset is released; in-flight operation discarded, no response issued.

Configuration
REQ-033 Macro ALU_OVF_TRAP_EN: when defined, ovf_trap and trap_clr exist; ovf_trap sets on EXEC capture when op is ALU_ADD or ALU_SUB and alu_overflow=1, stays set until trap_clr=1 or reset.
REQ-034 Simultaneous set and trap_clr in same cycle: set wins, ovf_trap=1.
REQ-035 Trap never blocks the response; response still delivered normally.
REQ-036 Without ALU_OVF_TRAP_EN: ports ovf_trap and trap_clr absent, no trap logic; all other behaviour identical.

Verification
REQ-037 ALU_ADD a=0x7FFFFFFF b=0x00000001, resp_ready=1 -> resp_valid at N+2, resp_out=0x80000000, negative=1, overflow=1, zero=0, perf_cnt=1.
REQ-038 ALU_SUB a=5 b=5 -> resp_out=0, zero=1, negative=0; req_ready low for exactly 2 cycles after accept.
REQ-039 ALU_SLT a=0xFFFFFFFF b=1, resp_ready held 0 for 4 cycles -> resp_out=1 stable across all 4 cycles, req_ready=0, req_valid pulses ignored.
REQ-040 RST asserted during EXEC -> next cycle state IDLE, resp_valid=0, perf_cnt unchanged-to-0, req_ready=1 after release.
REQ-041 CNT_W=2, five back-to-back ALU_OR operations -> perf_cnt sequence 1,2,3,3,3.
REQ-042 ALU_OVF_TRAP_EN defined: ADD overflow -> ovf_trap=1 after EXEC; overflow coinciding with trap_clr -> ovf_trap stays 1; trap_clr alone -> 0 next cycle.
